// File: rtl/mac_job_scheduler.sv
// mac_job_scheduler: job FIFO plus dispatch FSM in front of the matrix MAC.
// Jobs are queued, issued one at a time over the MAC valid/ready handshake,
// guarded by a watchdog, and retired with one completion record each.
// Optional feature: define MAC_SCHED_PERF_EN to build the per-job cycle
// counter that drives done_cycles; otherwise done_cycles is tied to 0.
`timescale 1ns/1ps
module mac_job_scheduler #(
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [ADDR_W-1:0] job_weight_base,
  input  logic [ADDR_W-1:0] job_result_start,
  input  logic [TAG_W-1:0]  job_tag,
  input  logic              flush,
  output logic              mac_valid,
  input  logic              mac_ready,
  output logic [ADDR_W-1:0] mac_weight_base,
  output logic [ADDR_W-1:0] mac_result_start,
  output logic              done_valid,
  output logic [TAG_W-1:0]  done_tag,
  output logic              done_timeout,
  output logic [31:0]       done_cycles,
  output logic              busy,
  output logic [4:0]        queue_count
);

  localparam int          PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]  DEPTH_CNT   = 5'(DEPTH);
  localparam logic [19:0] TIMEOUT_CNT = 20'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    RUN,
    DONE
  } state_t;

  state_t state;

  logic [ADDR_W-1:0] weight_mem [DEPTH];
  logic [ADDR_W-1:0] result_mem [DEPTH];
  logic [TAG_W-1:0]  tag_mem    [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [4:0]        count;
  logic              push;
  logic              pop;

  logic [TAG_W-1:0]  tag_q;
  logic [19:0]       wd;
  logic [19:0]       wd_inc;
  logic              hit_limit;
  logic              to_done;

  assign job_ready   = (count != DEPTH_CNT);
  assign queue_count = count;
  assign push        = job_valid && job_ready && !flush;
  assign pop         = (state == IDLE) && (count != 5'd0) && mac_ready && !flush;

  assign wd_inc    = wd + 20'd1;
  assign hit_limit = (wd_inc == TIMEOUT_CNT);
  assign to_done   = ((state == WAIT_ACK) && hit_limit) ||
                     ((state == RUN) && (mac_ready || hit_limit));

  assign mac_valid  = (state == ISSUE);
  assign done_valid = (state == DONE);
  assign busy       = (state != IDLE) || (count != 5'd0);

  // Job payload storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      weight_mem[wr_ptr] <= job_weight_base;
      result_mem[wr_ptr] <= job_result_start;
      tag_mem[wr_ptr]    <= job_tag;
    end
  end

  // FIFO pointers and occupancy; flush empties the queue but not the MAC job.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 5'd0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 5'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 5'd1;
      end else if (pop && !push) begin
        count <= count - 5'd1;
      end
    end
  end

  // Dispatch FSM: pop, strobe the MAC, follow its ready, retire with status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      mac_weight_base  <= '0;
      mac_result_start <= '0;
      tag_q            <= '0;
      wd               <= '0;
      done_tag         <= '0;
      done_timeout     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            mac_weight_base  <= weight_mem[rd_ptr];
            mac_result_start <= result_mem[rd_ptr];
            tag_q            <= tag_mem[rd_ptr];
            wd               <= '0;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          wd <= wd_inc;
          // The limit wins here so the counter can never step past TIMEOUT
          // on the way into RUN.
          if (hit_limit) begin
            state        <= DONE;
            done_tag     <= tag_q;
            done_timeout <= 1'b1;
          end else if (!mac_ready) begin
            state <= RUN;
          end
        end
        RUN: begin
          wd <= wd_inc;
          if (mac_ready) begin
            state        <= DONE;
            done_tag     <= tag_q;
            done_timeout <= 1'b0;
          end else if (hit_limit) begin
            state        <= DONE;
            done_tag     <= tag_q;
            done_timeout <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MAC_SCHED_PERF_EN
  logic [31:0] perf;
  logic [31:0] perf_inc;
  logic [31:0] done_cycles_q;

  assign perf_inc    = (perf == 32'hFFFF_FFFF) ? perf : perf + 32'd1;
  assign done_cycles = done_cycles_q;

  // Per-job cycle count, latched on the way into DONE and held until the next one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf          <= 32'd0;
      done_cycles_q <= 32'd0;
    end else begin
      if (pop) begin
        perf <= 32'd0;
      end else if ((state == ISSUE) || (state == WAIT_ACK) || (state == RUN)) begin
        perf <= perf_inc;
      end
      if (to_done) begin
        done_cycles_q <= perf_inc;
      end
    end
  end
`else
  logic unused_to_done;
  assign unused_to_done = to_done;
  assign done_cycles    = 32'd0;
`endif

endmodule

// File: tb/tb_mac_job_scheduler.sv
// tb_mac_job_scheduler: directed scenarios with randomized job payloads and
// MAC run lengths, checked against a queue-based model of the job stream.
`timescale 1ns/1ps
module tb_mac_job_scheduler;

  localparam int ADDR_W  = 16;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 50;

  typedef struct packed {
    logic [ADDR_W-1:0] weight;
    logic [ADDR_W-1:0] result;
    logic [TAG_W-1:0]  tag;
  } job_t;

  logic              clk;
  logic              reset_n;
  logic              job_valid;
  logic              job_ready;
  logic [ADDR_W-1:0] job_weight_base;
  logic [ADDR_W-1:0] job_result_start;
  logic [TAG_W-1:0]  job_tag;
  logic              flush;
  logic              mac_valid;
  logic              mac_ready;
  logic [ADDR_W-1:0] mac_weight_base;
  logic [ADDR_W-1:0] mac_result_start;
  logic              done_valid;
  logic [TAG_W-1:0]  done_tag;
  logic              done_timeout;
  logic [31:0]       done_cycles;
  logic              busy;
  logic [4:0]        queue_count;

  job_t model_q[$];
  int   check_count = 0;
  int   pass_count  = 0;
  int   fail_count  = 0;

  mac_job_scheduler #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .TAG_W  (TAG_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .job_valid       (job_valid),
    .job_ready       (job_ready),
    .job_weight_base (job_weight_base),
    .job_result_start(job_result_start),
    .job_tag         (job_tag),
    .flush           (flush),
    .mac_valid       (mac_valid),
    .mac_ready       (mac_ready),
    .mac_weight_base (mac_weight_base),
    .mac_result_start(mac_result_start),
    .done_valid      (done_valid),
    .done_tag        (done_tag),
    .done_timeout    (done_timeout),
    .done_cycles     (done_cycles),
    .busy            (busy),
    .queue_count     (queue_count)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a scenario wedges.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: observed still running, expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic check_output(input string name, input logic [31:0] observed,
                              input logic [31:0] expected);
    check_count++;
    assert (observed === expected) begin
      pass_count++;
    end else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic job_t rand_job(input int t);
    job_t j;
    j.weight = ADDR_W'($urandom);
    j.result = ADDR_W'($urandom);
    j.tag    = TAG_W'(t);
    return j;
  endfunction

  function automatic logic [31:0] exp_cycles(input int ticks);
`ifdef MAC_SCHED_PERF_EN
    return 32'(ticks);
`else
    return (ticks > 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  // One push attempt; only used when the scheduler cannot pop in the same edge.
  task automatic apply_stimulus(input job_t j);
    logic expect_accept;
    expect_accept = (model_q.size() < DEPTH);
    job_valid        = 1'b1;
    job_weight_base  = j.weight;
    job_result_start = j.result;
    job_tag          = j.tag;
    check_output("job_ready_before_push", job_ready, expect_accept);
    tick();
    job_valid = 1'b0;
    if (expect_accept) model_q.push_back(j);
    check_output("queue_count_after_push", queue_count, model_q.size());
  endtask

  task automatic wait_issue(input int budget);
    int n;
    n = 0;
    while (!mac_valid && n < budget) begin
      tick();
      n++;
    end
    check_output("issue_within_budget", mac_valid, 1'b1);
  endtask

  // Entered with the ISSUE cycle sampled; plays the MAC and checks the retire record.
  task automatic run_job(input int run_len, input int flush_at);
    job_t j;
    int   ticks;
    int   waited;
    logic early;
    j = model_q.pop_front();
    check_output("mac_valid_on_issue", mac_valid, 1'b1);
    check_output("mac_weight_base", mac_weight_base, j.weight);
    check_output("mac_result_start", mac_result_start, j.result);
    check_output("queue_count_after_pop", queue_count, model_q.size());
    tick();
    ticks = 1;
    check_output("mac_valid_single_cycle", mac_valid, 1'b0);
    mac_ready = 1'b0;
    early = 1'b0;
    for (int k = 0; k < run_len; k++) begin
      if (k == flush_at) begin
        flush     = 1'b1;
        job_valid = 1'b1;
        job_tag   = 4'hF;
      end
      tick();
      ticks++;
      if (done_valid || mac_valid) early = 1'b1;
      if (flush) begin
        flush     = 1'b0;
        job_valid = 1'b0;
        model_q.delete();
        check_output("queue_count_after_flush", queue_count, 0);
      end
    end
    check_output("no_early_done", early, 1'b0);
    mac_ready = 1'b1;
    waited = 0;
    do begin
      tick();
      ticks++;
      waited++;
    end while (!done_valid && waited < 10);
    check_output("done_latency", waited, 1);
    check_output("done_valid", done_valid, 1'b1);
    check_output("done_tag", done_tag, j.tag);
    check_output("done_timeout", done_timeout, 1'b0);
    check_output("done_cycles", done_cycles, exp_cycles(ticks));
    check_output("addr_hold", mac_weight_base, j.weight);
    check_output("busy_in_done", busy, 1'b1);
    tick();
    check_output("done_single_cycle", done_valid, 1'b0);
  endtask

  // Directed scenario sequence.
  initial begin
    job_t j;
    int   wd_ticks;
    logic quiet_bad;

    reset_n          = 1'b0;
    job_valid        = 1'b0;
    job_weight_base  = '0;
    job_result_start = '0;
    job_tag          = '0;
    flush            = 1'b0;
    mac_ready        = 1'b1;
    #12;
    check_output("reset_mac_valid", mac_valid, 1'b0);
    check_output("reset_done_valid", done_valid, 1'b0);
    check_output("reset_job_ready", job_ready, 1'b1);
    check_output("reset_queue_count", queue_count, 0);
    check_output("reset_busy", busy, 1'b0);
    check_output("reset_weight_base", mac_weight_base, 0);
    check_output("reset_done_cycles", done_cycles, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    $display("[TB] single job");
    j.weight = 16'h0010;
    j.result = 16'h0040;
    j.tag    = 4'd3;
    apply_stimulus(j);
    tick();
    run_job(20, -1);

    $display("[TB] fill and backpressure");
    mac_ready = 1'b0;
    for (int t = 0; t < 5; t++) apply_stimulus(rand_job(t));
    check_output("fill_queue_count", queue_count, 4);
    check_output("fill_job_ready", job_ready, 1'b0);
    mac_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      wait_issue(4);
      run_job(int'($urandom_range(1, 30)), -1);
    end

    $display("[TB] flush");
    mac_ready = 1'b0;
    for (int t = 0; t < 3; t++) apply_stimulus(rand_job(8 + t));
    mac_ready = 1'b1;
    wait_issue(4);
    run_job(15, 5);
    quiet_bad = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (mac_valid) quiet_bad = 1'b1;
    end
    check_output("no_issue_after_flush", quiet_bad, 1'b0);
    check_output("flush_queue_count", queue_count, 0);
    check_output("flush_busy", busy, 1'b0);

    $display("[TB] simultaneous push and pop");
    mac_ready = 1'b0;
    apply_stimulus(rand_job(1));
    apply_stimulus(rand_job(2));
    j = rand_job(9);
    mac_ready        = 1'b1;
    job_valid        = 1'b1;
    job_weight_base  = j.weight;
    job_result_start = j.result;
    job_tag          = j.tag;
    check_output("simul_job_ready_before", job_ready, 1'b1);
    tick();
    job_valid = 1'b0;
    model_q.push_back(j);
    check_output("simul_queue_count", queue_count, 2);
    check_output("simul_job_ready", job_ready, 1'b1);
    run_job(int'($urandom_range(1, 30)), -1);
    for (int t = 0; t < 2; t++) begin
      wait_issue(4);
      run_job(int'($urandom_range(1, 30)), -1);
    end

    $display("[TB] watchdog timeout");
    mac_ready = 1'b0;
    apply_stimulus(rand_job(5));
    apply_stimulus(rand_job(6));
    mac_ready = 1'b1;
    wait_issue(4);
    j = model_q.pop_front();
    check_output("to_weight_base", mac_weight_base, j.weight);
    tick();
    mac_ready = 1'b0;
    wd_ticks = 0;
    do begin
      tick();
      wd_ticks++;
    end while (!done_valid && wd_ticks < 80);
    check_output("timeout_latency", wd_ticks, TIMEOUT);
    check_output("timeout_done_valid", done_valid, 1'b1);
    check_output("timeout_flag", done_timeout, 1'b1);
    check_output("timeout_tag", done_tag, j.tag);
    check_output("timeout_cycles", done_cycles, exp_cycles(TIMEOUT + 1));
    quiet_bad = 1'b0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (mac_valid) quiet_bad = 1'b1;
    end
    check_output("no_issue_while_hung", quiet_bad, 1'b0);
    check_output("hung_queue_count", queue_count, 1);
    check_output("hung_busy", busy, 1'b1);
    mac_ready = 1'b1;
    wait_issue(4);
    run_job(int'($urandom_range(1, 30)), -1);

    $display("[TB] async reset mid-run");
    mac_ready = 1'b0;
    apply_stimulus(rand_job(12));
    apply_stimulus(rand_job(13));
    mac_ready = 1'b1;
    wait_issue(4);
    tick();
    mac_ready = 1'b0;
    repeat (5) tick();
    #3;
    reset_n = 1'b0;
    #1;
    check_output("rst_mac_valid", mac_valid, 1'b0);
    check_output("rst_done_valid", done_valid, 1'b0);
    check_output("rst_queue_count", queue_count, 0);
    check_output("rst_job_ready", job_ready, 1'b1);
    check_output("rst_busy", busy, 1'b0);
    model_q.delete();
    mac_ready = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    quiet_bad = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (done_valid || mac_valid) quiet_bad = 1'b1;
    end
    check_output("no_pulse_after_reset", quiet_bad, 1'b0);

    $display("[TB] random single jobs");
    for (int r = 0; r < 6; r++) begin
      apply_stimulus(rand_job(r));
      tick();
      run_job(int'($urandom_range(1, 30)), -1);
    end

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
